// File: rtl/mon_dram_arbiter_if.sv
// rtl/mon_dram_arbiter_if.sv - data-RAM controller port shared by the monitor and the CPU
interface mon_dram_arbiter_if;
   logic         mem_req;
   logic         mem_we;
   logic [27:0]  mem_adr;
   logic [127:0] mem_wdata;
   logic [15:0]  mem_mask;
   logic         mem_ack;
   logic         mem_rvalid;
   logic [127:0] mem_rdata;

   // arbiter side
   modport master (
      output mem_req, mem_we, mem_adr, mem_wdata, mem_mask,
      input  mem_ack, mem_rvalid, mem_rdata
   );

   // RAM controller side
   modport slave (
      input  mem_req, mem_we, mem_adr, mem_wdata, mem_mask,
      output mem_ack, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mon_dram_arbiter.sv
// rtl/mon_dram_arbiter.sv - shares the 128-bit data-RAM port between the UART monitor and the CPU
module mon_dram_arbiter #(
   parameter int MWQ_DEPTH  = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mon_wen,
   input  logic [27:0]         mon_wadr,
   input  logic [127:0]        mon_wdata,
   input  logic [15:0]         mon_mask,
   input  logic                mon_rstart,
   input  logic [27:0]         mon_radr,
   output logic                mon_rvalid,
   output logic [127:0]        mon_rdata,
   output logic                mon_busy,
   output logic                mon_wovf,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [27:0]         cpu_adr,
   input  logic [127:0]        cpu_wdata,
   input  logic [15:0]         cpu_mask,
   output logic                cpu_gnt,
   output logic                cpu_rvalid,
   output logic [127:0]        cpu_rdata,
   mon_dram_arbiter_if.master  mem
);

   localparam int PW = (MWQ_DEPTH > 1) ? $clog2(MWQ_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(MWQ_DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RWAIT} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_MW, OWN_MR, OWN_CPU} owner_t;

   state_t state_q, state_d;
   owner_t owner_q, win;

   // monitor write FIFO
   logic [27:0]   q_adr  [MWQ_DEPTH];
   logic [127:0]  q_data [MWQ_DEPTH];
   logic [15:0]   q_mask [MWQ_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] q_cnt;
   logic          fifo_empty, fifo_full, push, pop, drop;

   // monitor read request
   logic          rd_pend;
   logic [27:0]   rd_adr_q;
   logic          rd_take, rd_elig;

   // starvation guard
   logic [SW-1:0] starve_cnt;
   logic          cpu_force;

   // registered request towards the RAM controller
   logic          req_we_q;
   logic [27:0]   req_adr_q;
   logic [127:0]  req_wdata_q;
   logic [15:0]   req_mask_q;

   logic          win_we;
   logic [27:0]   win_adr;
   logic [127:0]  win_wdata;
   logic [15:0]   win_mask;

   assign fifo_empty = (q_cnt == '0);
   assign fifo_full  = (q_cnt == FULL_CNT);
   // an entry leaves the FIFO only once the controller has taken it
   assign pop        = (state_q == S_REQ) && (owner_q == OWN_MW) && mem.mem_ack;
   // a full FIFO still accepts a push when it is popping in the same cycle
   assign push       = mon_wen && (!fifo_full || pop);
   assign drop       = mon_wen && fifo_full && !pop;

   // rd_pend stays set until the data returns, so it also covers an in-flight read
   assign rd_take    = mon_rstart && !rd_pend;
   // reads wait behind every buffered or arriving monitor write
   assign rd_elig    = (rd_pend || rd_take) && fifo_empty && !mon_wen;
   assign cpu_force  = cpu_req && (starve_cnt == STARVE_MAX);

   // FIFO storage write
   always_ff @(posedge clk) begin
      if (push) begin
         q_adr[wr_ptr]  <= mon_wadr;
         q_data[wr_ptr] <= mon_wdata;
         q_mask[wr_ptr] <= mon_mask;
      end
   end

   // FIFO pointers, fill count and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         q_cnt    <= '0;
         mon_wovf <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   q_cnt <= q_cnt + 1'b1;
            2'b01:   q_cnt <= q_cnt - 1'b1;
            default: q_cnt <= q_cnt;
         endcase
         if (drop) mon_wovf <= 1'b1;
      end
   end

   // pending monitor read: latched on start, released when its data returns
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend  <= 1'b0;
         rd_adr_q <= '0;
      end else if (rd_take) begin
         rd_pend  <= 1'b1;
         rd_adr_q <= mon_radr;
      end else if (state_q == S_RWAIT && mem.mem_rvalid && owner_q == OWN_MR) begin
         rd_pend  <= 1'b0;
      end
   end

   // arbitration and next state
   always_comb begin
      state_d = state_q;
      win     = OWN_NONE;
      case (state_q)
         S_IDLE: begin
            if (cpu_force)        win = OWN_CPU;
            else if (!fifo_empty) win = OWN_MW;
            else if (rd_elig)     win = OWN_MR;
            else if (cpu_req)     win = OWN_CPU;
            if (win != OWN_NONE) state_d = S_REQ;
         end
         S_REQ: begin
            if (mem.mem_ack) state_d = req_we_q ? S_IDLE : S_RWAIT;
         end
         S_RWAIT: begin
            if (mem.mem_rvalid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // request fields of the arbitration winner
   always_comb begin
      win_we    = 1'b0;
      win_adr   = '0;
      win_wdata = '0;
      win_mask  = '0;
      case (win)
         OWN_MW: begin
            win_we    = 1'b1;
            win_adr   = q_adr[rd_ptr];
            win_wdata = q_data[rd_ptr];
            win_mask  = q_mask[rd_ptr];
         end
         OWN_MR: begin
            win_adr   = rd_pend ? rd_adr_q : mon_radr;
         end
         OWN_CPU: begin
            win_we    = cpu_we;
            win_adr   = cpu_adr;
            win_wdata = cpu_wdata;
            win_mask  = cpu_mask;
         end
         default: ;
      endcase
   end

   // state register; owner and request fields frozen at grant until completion
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_NONE;
         req_we_q    <= 1'b0;
         req_adr_q   <= '0;
         req_wdata_q <= '0;
         req_mask_q  <= '0;
      end else begin
         state_q <= state_d;
         if (win != OWN_NONE) begin
            owner_q     <= win;
            req_we_q    <= win_we;
            req_adr_q   <= win_adr;
            req_wdata_q <= win_wdata;
            req_mask_q  <= win_mask;
         end
      end
   end

   // count monitor grants that pass over a waiting CPU request
   always_ff @(posedge clk) begin
      if (rst || !cpu_req || win == OWN_CPU) begin
         starve_cnt <= '0;
      end else if ((win == OWN_MW || win == OWN_MR) && starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // route returning read data to its owner, one cycle after mem_rvalid
   always_ff @(posedge clk) begin
      if (rst) begin
         mon_rvalid <= 1'b0;
         cpu_rvalid <= 1'b0;
         mon_rdata  <= '0;
         cpu_rdata  <= '0;
      end else begin
         mon_rvalid <= 1'b0;
         cpu_rvalid <= 1'b0;
         if (state_q == S_RWAIT && mem.mem_rvalid) begin
            if (owner_q == OWN_MR) begin
               mon_rvalid <= 1'b1;
               mon_rdata  <= mem.mem_rdata;
            end
            if (owner_q == OWN_CPU) begin
               cpu_rvalid <= 1'b1;
               cpu_rdata  <= mem.mem_rdata;
            end
         end
      end
   end

   assign mem.mem_req   = (state_q == S_REQ);
   assign mem.mem_we    = (state_q == S_REQ) && req_we_q;
   assign mem.mem_adr   = req_adr_q;
   assign mem.mem_wdata = req_wdata_q;
   assign mem.mem_mask  = req_mask_q;

   assign cpu_gnt  = (state_q == S_REQ) && (owner_q == OWN_CPU) && mem.mem_ack;
   assign mon_busy = !fifo_empty || rd_pend ||
                     ((owner_q == OWN_MW || owner_q == OWN_MR) && state_q != S_IDLE);

endmodule

// File: tb/tb_mon_dram_arbiter.sv
// tb/tb_mon_dram_arbiter.sv - directed self-checking bench for mon_dram_arbiter
module tb_mon_dram_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic         mon_wen, mon_rstart, mon_rvalid, mon_busy, mon_wovf;
   logic [27:0]  mon_wadr, mon_radr;
   logic [127:0] mon_wdata, mon_rdata;
   logic [15:0]  mon_mask;
   logic         cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [27:0]  cpu_adr;
   logic [127:0] cpu_wdata, cpu_rdata;
   logic [15:0]  cpu_mask;

   mon_dram_arbiter_if mem_bus ();

   mon_dram_arbiter #(.MWQ_DEPTH(4), .STARVE_LIM(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .mon_wen    (mon_wen),
      .mon_wadr   (mon_wadr),
      .mon_wdata  (mon_wdata),
      .mon_mask   (mon_mask),
      .mon_rstart (mon_rstart),
      .mon_radr   (mon_radr),
      .mon_rvalid (mon_rvalid),
      .mon_rdata  (mon_rdata),
      .mon_busy   (mon_busy),
      .mon_wovf   (mon_wovf),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_adr    (cpu_adr),
      .cpu_wdata  (cpu_wdata),
      .cpu_mask   (cpu_mask),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .mem        (mem_bus.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM controller model: acks any request when enabled, returns read data rv_delay cycles later
   int           ack_en   = 1;
   int           rv_delay = 2;
   int           rv_cnt   = 0;
   logic [127:0] rd_data  = '0;
   logic [27:0]  log_adr[$];
   logic         log_we[$];
   logic [127:0] log_wdata[$];
   logic [15:0]  log_mask[$];

   always @(negedge clk) begin
      mem_bus.mem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
         rv_cnt--;
         if (rv_cnt == 0) begin
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata  = rd_data;
         end
      end
      mem_bus.mem_ack = mem_bus.mem_req && (ack_en != 0);
      if (mem_bus.mem_ack) begin
         log_adr.push_back(mem_bus.mem_adr);
         log_we.push_back(mem_bus.mem_we);
         log_wdata.push_back(mem_bus.mem_wdata);
         log_mask.push_back(mem_bus.mem_mask);
         if (!mem_bus.mem_we) rv_cnt = rv_delay;
      end
   end

   // output observer, sampled mid-cycle
   int           cyc = 0;
   int           mon_rv_n = 0, cpu_rv_n = 0, gnt_n = 0, gnt_run = 0, gnt_run_max = 0;
   int           mon_rv_cyc = 0, gnt_cyc = 0;
   logic [127:0] last_mon = '0, last_cpu = '0;

   always @(posedge clk) cyc++;

   always begin
      @(negedge clk);
      #2;
      if (mon_rvalid === 1'b1) begin
         mon_rv_n++;
         last_mon   = mon_rdata;
         mon_rv_cyc = cyc;
      end
      if (cpu_rvalid === 1'b1) begin
         cpu_rv_n++;
         last_cpu = cpu_rdata;
      end
      if (cpu_gnt === 1'b1) begin
         gnt_n++;
         gnt_run++;
         gnt_cyc = cyc;
         if (gnt_run > gnt_run_max) gnt_run_max = gnt_run;
      end else begin
         gnt_run = 0;
      end
   end

   function automatic logic [127:0] lg(input int field, input int i);
      if (i >= log_adr.size()) return '1;
      case (field)
         0:       return 128'(log_adr[i]);
         1:       return 128'(log_we[i]);
         2:       return log_wdata[i];
         default: return 128'(log_mask[i]);
      endcase
   endfunction

   task automatic wait_log(input int n, input int maxc, input string tag);
      int k = 0;
      while (log_adr.size() < n && k < maxc) begin
         @(negedge clk);
         k++;
      end
      check(tag, 128'(log_adr.size() >= n), 128'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   localparam logic [127:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
   localparam logic [127:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] D3 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
   localparam logic [127:0] D4 = 128'h0f0f_0f0f_0f0f_0f0f_f0f0_f0f0_f0f0_f0f0;
   localparam logic [127:0] D5 = 128'h9876_5432_1000_0001_abcd_ef01_2345_6789;

   initial begin
      int base, rv0, cr0, g0, k;
      bit gs;

      rst = 1'b1;
      mon_wen = 0; mon_wadr = '0; mon_wdata = '0; mon_mask = '0;
      mon_rstart = 0; mon_radr = '0;
      cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wdata = '0; cpu_mask = '0;

      // reset state
      repeat (3) @(negedge clk);
      #2;
      check("rst_mem_req",    128'(mem_bus.mem_req), 0);
      check("rst_mem_we",     128'(mem_bus.mem_we), 0);
      check("rst_mem_adr",    128'(mem_bus.mem_adr), 0);
      check("rst_mem_wdata",  mem_bus.mem_wdata, 0);
      check("rst_mem_mask",   128'(mem_bus.mem_mask), 0);
      check("rst_mon_rvalid", 128'(mon_rvalid), 0);
      check("rst_mon_rdata",  mon_rdata, 0);
      check("rst_mon_busy",   128'(mon_busy), 0);
      check("rst_mon_wovf",   128'(mon_wovf), 0);
      check("rst_cpu_gnt",    128'(cpu_gnt), 0);
      check("rst_cpu_rvalid", 128'(cpu_rvalid), 0);
      check("rst_cpu_rdata",  cpu_rdata, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("idle_mem_req",  128'(mem_bus.mem_req), 0);
      check("idle_mon_busy", 128'(mon_busy), 0);
      rv_delay = 4;

      // reset while a monitor read waits for its data; the late mem_rvalid must be ignored
      base = log_adr.size();
      rv0  = mon_rv_n;
      @(negedge clk);
      mon_rstart = 1; mon_radr = 28'h30;
      @(negedge clk);
      mon_rstart = 0;
      @(negedge clk);
      #2;
      check("rwait_busy", 128'(mon_busy), 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      check("rwait_rd_logged", lg(0, base), 128'h30);
      check("rwait_no_rvalid", 128'(mon_rv_n - rv0), 0);
      check("rwait_busy_clr",  128'(mon_busy), 0);
      check("rwait_mem_req",   128'(mem_bus.mem_req), 0);
      rv_delay = 2;

      // three monitor writes with immediate acks
      base = log_adr.size();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mon_wen = 1; mon_wadr = 28'h10 + 28'(i); mon_wdata = D1; mon_mask = 16'hfff0;
      end
      @(negedge clk);
      mon_wen = 0;
      wait_log(base + 3, 40, "w3_done");
      repeat (4) @(negedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("w3_adr%0d", i),  lg(0, base + i), 128'h10 + 128'(i));
         check($sformatf("w3_we%0d", i),   lg(1, base + i), 1);
         check($sformatf("w3_data%0d", i), lg(2, base + i), D1);
         check($sformatf("w3_mask%0d", i), lg(3, base + i), 128'hfff0);
      end
      check("w3_count", 128'(log_adr.size() - base), 3);
      check("w3_busy",  128'(mon_busy), 0);
      check("w3_wovf",  128'(mon_wovf), 0);

      // overflow: five writes while the controller stalls
      ack_en = 0;
      base = log_adr.size();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mon_wen = 1; mon_wadr = 28'h40 + 28'(i); mon_wdata = D2; mon_mask = 16'h0;
      end
      @(negedge clk);
      mon_wen = 0;
      repeat (2) @(negedge clk);
      #2;
      check("ovf_wovf",    128'(mon_wovf), 1);
      check("ovf_mem_req", 128'(mem_bus.mem_req), 1);
      check("ovf_mem_adr", 128'(mem_bus.mem_adr), 128'h40);
      check("ovf_busy",    128'(mon_busy), 1);
      ack_en = 1;
      wait_log(base + 4, 40, "ovf_done");
      repeat (10) @(negedge clk);
      #2;
      check("ovf_count", 128'(log_adr.size() - base), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("ovf_adr%0d", i), lg(0, base + i), 128'h40 + 128'(i));
      check("ovf_wovf_sticky", 128'(mon_wovf), 1);
      rst = 1'b1;
      @(negedge clk);
      #2;
      check("ovf_wovf_rst", 128'(mon_wovf), 0);
      rst = 1'b0;
      @(negedge clk);

      // write followed by a read of the same line
      #2;
      rd_data = {16{8'ha5}};
      base = log_adr.size();
      rv0  = mon_rv_n;
      @(negedge clk);
      mon_wen = 1; mon_wadr = 28'h20; mon_wdata = D3; mon_mask = 16'h00ff;
      @(negedge clk);
      mon_wen = 0; mon_rstart = 1; mon_radr = 28'h20;
      @(negedge clk);
      mon_rstart = 0;
      k = 0;
      while (mon_rv_n < rv0 + 1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
      #2;
      check("wr_first_we",  lg(1, base), 1);
      check("wr_first_adr", lg(0, base), 128'h20);
      check("rd_second_we", lg(1, base + 1), 0);
      check("rd_second_adr", lg(0, base + 1), 128'h20);
      check("rd_rvalid_n",  128'(mon_rv_n - rv0), 1);
      check("rd_rdata",     last_mon, {16{8'ha5}});
      check("rd_busy",      128'(mon_busy), 0);

      // CPU read starved by a continuous monitor fill
      rd_data = 128'hcafe_f00d_0000_0000_1234_5678_9abc_def0;
      base = log_adr.size();
      g0   = gnt_n;
      cr0  = cpu_rv_n;
      gs   = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         mon_wen   = (c % 2 == 0) && (c < 28);
         mon_wadr  = 28'h100 + 28'(c / 2);
         mon_wdata = D4;
         mon_mask  = 16'h0f0f;
         cpu_req   = (c >= 1) && !gs;
         cpu_we    = 0;
         cpu_adr   = 28'h77;
         #2;
         if (cpu_gnt === 1'b1) gs = 1;
      end
      mon_wen = 0;
      cpu_req = 0;
      wait_log(base + 15, 40, "starve_done");
      #2;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("starve_mon_adr%0d", i), lg(0, base + i), 128'h100 + 128'(i));
         check($sformatf("starve_mon_we%0d", i),  lg(1, base + i), 1);
      end
      check("starve_cpu_we",     lg(1, base + 8), 0);
      check("starve_cpu_adr",    lg(0, base + 8), 128'h77);
      check("starve_resume_adr", lg(0, base + 9), 128'h108);
      check("starve_resume_we",  lg(1, base + 9), 1);
      check("starve_count",      128'(log_adr.size() - base), 15);
      check("starve_gnt_n",      128'(gnt_n - g0), 1);
      check("starve_rvalid_n",   128'(cpu_rv_n - cr0), 1);
      check("starve_rdata",      last_cpu, 128'hcafe_f00d_0000_0000_1234_5678_9abc_def0);
      check("starve_wovf",       128'(mon_wovf), 0);

      // monitor read and CPU write arrive together
      rd_data = {8{16'h5a3c}};
      base = log_adr.size();
      rv0  = mon_rv_n;
      g0   = gnt_n;
      cr0  = cpu_rv_n;
      gs   = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         mon_rstart = (c == 0);
         mon_radr   = 28'h60;
         cpu_req    = !gs;
         cpu_we     = 1;
         cpu_adr    = 28'h55;
         cpu_wdata  = D5;
         cpu_mask   = 16'h8001;
         #2;
         if (cpu_gnt === 1'b1) gs = 1;
      end
      cpu_req = 0;
      #2;
      check("mix_rd_we",     lg(1, base), 0);
      check("mix_rd_adr",    lg(0, base), 128'h60);
      check("mix_wr_we",     lg(1, base + 1), 1);
      check("mix_wr_adr",    lg(0, base + 1), 128'h55);
      check("mix_wr_data",   lg(2, base + 1), D5);
      check("mix_wr_mask",   lg(3, base + 1), 128'h8001);
      check("mix_count",     128'(log_adr.size() - base), 2);
      check("mix_mon_rv_n",  128'(mon_rv_n - rv0), 1);
      check("mix_mon_rdata", last_mon, {8{16'h5a3c}});
      check("mix_gnt_n",     128'(gnt_n - g0), 1);
      check("mix_gnt_after_rvalid", 128'(gnt_cyc > mon_rv_cyc), 1);
      check("gnt_single_cycle", 128'(gnt_run_max), 1);
      check("mix_no_cpu_rv", 128'(cpu_rv_n - cr0), 0);
      check("mix_busy",      128'(mon_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
